// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - clocked WIDTH-bit ALU with registered results and bit-serial variable shifts
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             ovf,
    output logic             take_branch
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] work_q;
    logic [SHW-1:0]   cnt_q;
    logic             arith_q;
    logic [WIDTH-1:0] f_q;
    logic             ovf_q;
    logic             tb_q;
    logic             done_q;
    logic             busy_q;

    logic [WIDTH:0]   sum_d;
    logic [WIDTH-1:0] shift_d;
    logic [SHW-1:0]   amt_d;

    always_comb begin
        sum_d   = {1'b0, a} + {1'b0, b};
        amt_d   = b[SHW-1:0];
        shift_d = arith_q ? {work_q[WIDTH-1], work_q[WIDTH-1:1]}
                          : {work_q[WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            arith_q <= 1'b0;
            f_q     <= '0;
            ovf_q   <= 1'b0;
            tb_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // Single-cycle ops commit here; only non-zero shifts leave IDLE.
                        done_q <= 1'b1;
                        ovf_q  <= 1'b0;
                        tb_q   <= 1'b0;
                        case (sel)
                            3'd0: begin
                                f_q   <= sum_d[WIDTH-1:0];
                                ovf_q <= sum_d[WIDTH];
                            end
                            3'd1: f_q <= ~b;
                            3'd2: f_q <= a & b;
                            3'd3: f_q <= a | b;
                            3'd4, 3'd5: begin
                                if (amt_d == '0) begin
                                    f_q <= a;
                                end else begin
                                    work_q  <= a;
                                    cnt_q   <= amt_d;
                                    arith_q <= (sel == 3'd4);
                                    state_q <= S_SHIFT;
                                    busy_q  <= 1'b1;
                                    done_q  <= 1'b0;
                                end
                            end
                            3'd6: begin
                                f_q  <= '0;
                                tb_q <= (a == b);
                            end
                            default: begin
                                f_q  <= '0;
                                tb_q <= (a != b);
                            end
                        endcase
                    end
                end
                S_SHIFT: begin
                    work_q <= shift_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == SHW'(1)) begin
                        f_q     <= shift_d;
                        ovf_q   <= 1'b0;
                        tb_q    <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign f           = f_q;
    assign ovf         = ovf_q;
    assign take_branch = tb_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq at WIDTH=8 and WIDTH=16
module tb_alu_seq;
    logic        clk;
    logic        rst_n;
    logic        start8, start16;
    logic [7:0]  a8, b8, f8;
    logic [15:0] a16, b16, f16;
    logic [2:0]  sel8, sel16;
    logic        busy8, done8, ovf8, tb8;
    logic        busy16, done16, ovf16, tb16;

    typedef struct {
        logic [15:0] f;
        logic        ovf;
        logic        tb;
        int          cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    int   cyc;
    int   checks;
    int   failures;
    int   nb;

    alu_seq #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .sel(sel8),
        .busy(busy8), .done(done8), .f(f8), .ovf(ovf8), .take_branch(tb8)
    );

    alu_seq #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .sel(sel16),
        .busy(busy16), .done(done16), .f(f16), .ovf(ovf16), .take_branch(tb16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                chk("w8_unexpected_done", 64'(f8), 64'hDEAD);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("w8_result", {46'h0, ovf8, tb8, 8'h0, f8}, {46'h0, e.ovf, e.tb, e.f});
                chk("w8_done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (done16 === 1'b1) begin
            if (q16.size() == 0) begin
                chk("w16_unexpected_done", 64'(f16), 64'hDEAD);
            end else begin
                exp_t e;
                e = q16.pop_front();
                chk("w16_result", {46'h0, ovf16, tb16, f16}, {46'h0, e.ovf, e.tb, e.f});
                chk("w16_done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Called just after an edge; the request is sampled at the next edge T.
    task automatic drive(input int inst, input logic [2:0] s, input logic [15:0] av,
                         input logic [15:0] bv, input logic [15:0] ef, input logic eo,
                         input logic et, input int lat, input bit push);
        exp_t e;
        e.f   = ef;
        e.ovf = eo;
        e.tb  = et;
        e.cyc = cyc + 1 + lat;
        if (inst == 0) begin
            start8 = 1'b1; sel8 = s; a8 = av[7:0]; b8 = bv[7:0];
            if (push) q8.push_back(e);
        end else begin
            start16 = 1'b1; sel16 = s; a16 = av; b16 = bv;
            if (push) q16.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic rel();
        start8  = 1'b0;
        start16 = 1'b0;
    endtask

    task automatic wait_idle(input int inst, output int n);
        n = 0;
        while (((inst == 0) ? busy8 : busy16) && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        if (n >= 100) chk("busy_timeout", 64'(n), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; rel();
        a8 = '0; b8 = '0; sel8 = '0; a16 = '0; b16 = '0; sel16 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_w8_outputs", {59'h0, busy8, done8, ovf8, tb8, |f8}, 64'h0);
        chk("reset_w16_outputs", {43'h0, busy16, done16, ovf16, tb16, f16}, 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        drive(0, 3'd0, 16'hFF, 16'h01, 16'h00, 1'b1, 1'b0, 0, 1'b1); rel();
        chk("add_busy_low", 64'(busy8), 64'h0);
        @(posedge clk); #1;
        drive(0, 3'd0, 16'h40, 16'h40, 16'h80, 1'b0, 1'b0, 0, 1'b1); rel();
        @(posedge clk); #1;

        drive(0, 3'd1, 16'h00, 16'hAA, 16'h55, 1'b0, 1'b0, 0, 1'b1);
        drive(0, 3'd2, 16'hF0, 16'h3C, 16'h30, 1'b0, 1'b0, 0, 1'b1);
        drive(0, 3'd3, 16'hF0, 16'h3C, 16'hFC, 1'b0, 1'b0, 0, 1'b1);
        drive(0, 3'd6, 16'h5A, 16'h5A, 16'h00, 1'b0, 1'b1, 0, 1'b1);
        drive(0, 3'd7, 16'h5A, 16'h5A, 16'h00, 1'b0, 1'b0, 0, 1'b1);
        rel();
        @(posedge clk); #1;

        drive(0, 3'd4, 16'h80, 16'h03, 16'hF0, 1'b0, 1'b0, 3, 1'b1); rel();
        wait_idle(0, nb); chk("asr3_busy_cycles", 64'(nb), 64'd3);
        drive(0, 3'd5, 16'h01, 16'h07, 16'h80, 1'b0, 1'b0, 7, 1'b1); rel();
        wait_idle(0, nb); chk("lsl7_busy_cycles", 64'(nb), 64'd7);
        drive(0, 3'd5, 16'h5B, 16'h00, 16'h5B, 1'b0, 1'b0, 0, 1'b1); rel();
        wait_idle(0, nb); chk("lsl0_busy_cycles", 64'(nb), 64'd0);

        drive(0, 3'd5, 16'h03, 16'h04, 16'h30, 1'b0, 1'b0, 4, 1'b1); rel();
        start8 = 1'b1; sel8 = 3'd0; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk); #1;
        a8 = 8'h11; b8 = 8'h22;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_idle(0, nb); chk("protect_busy_remaining", 64'(nb), 64'd2);
        @(posedge clk); #1;

        drive(0, 3'd4, 16'h81, 16'h06, 16'h00, 1'b0, 1'b0, 6, 1'b0); rel();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midshift_reset_outputs", {59'h0, busy8, done8, ovf8, tb8, |f8}, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        drive(0, 3'd0, 16'h12, 16'h34, 16'h46, 1'b0, 1'b0, 0, 1'b1); rel();
        @(posedge clk); #1;

        drive(1, 3'd0, 16'hFFFF, 16'h0002, 16'h0001, 1'b1, 1'b0, 0, 1'b1); rel();
        @(posedge clk); #1;
        drive(1, 3'd4, 16'h8000, 16'h000F, 16'hFFFF, 1'b0, 1'b0, 15, 1'b1); rel();
        wait_idle(1, nb); chk("w16_asr15_busy_cycles", 64'(nb), 64'd15);

        repeat (3) @(posedge clk);
        #1;
        chk("w8_pending_results", 64'(q8.size()), 64'd0);
        chk("w16_pending_results", 64'(q16.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
